io_stream_read_array_burst: RTL and testbench

// - Parametrised successor of the stream-to-array reader: accepts a command (base, len), drains len

---
 rtl/io_stream_read_array_burst_if.sv | 32 +++
 rtl/io_stream_read_array_burst.sv | 110 +++++++++++
 tb/tb_io_stream_read_array_burst.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_stream_read_array_burst_if.sv
// Handshake bundle for io_stream_read_array_burst: command, input stream, array write port, result.
// The block itself uses the slave view; the surrounding producer/array/consumer use the master view.
interface io_stream_read_array_burst_if #(
  parameter int INT_N  = 8,
  parameter int ADDR_N = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_N-1:0] base;
  logic [ADDR_N:0]   len;
  logic [INT_N-1:0]  sIn;
  logic              sIn_valid;
  logic              sIn_ready;
  logic [ADDR_N-1:0] arr_addr;
  logic              arr_we;
  logic [INT_N-1:0]  arr_di;
  logic              arr_valid;
  logic              arr_ready;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_N:0]   out_count;

  modport slave (
    input  in_valid, base, len, sIn, sIn_valid, arr_ready, out_ready,
    output in_ready, sIn_ready, arr_addr, arr_we, arr_di, arr_valid, out_valid, out_count
  );

  modport master (
    output in_valid, base, len, sIn, sIn_valid, arr_ready, out_ready,
    input  in_ready, sIn_ready, arr_addr, arr_we, arr_di, arr_valid, out_valid, out_count
  );
endinterface

// File: rtl/io_stream_read_array_burst.sv
// Drains len words from a stream into consecutive array addresses starting at base, then reports count.
// Optional terminator handling is enabled by defining IO_STREAM_READ_ARRAY_TERM_EN.
module io_stream_read_array_burst #(
  parameter int               INT_N  = 8,
  parameter int               ADDR_N = 8,
  parameter logic [INT_N-1:0] TERM   = '0
) (
  input logic                     clk,
  input logic                     nrst,
  io_stream_read_array_burst_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [ADDR_N:0]   remaining;
  logic [ADDR_N-1:0] ptr;
  logic [ADDR_N:0]   count;

  logic              vld_p1;
  logic [ADDR_N-1:0] arr_addr_p1;
  logic [INT_N-1:0]  arr_di_p1;

  logic              slot_free;
  logic              cmd_fire;
  logic              sin_fire;
  logic              is_term;
  logic              out_fire;

  function automatic logic is_terminator(input logic [INT_N-1:0] w);
`ifdef IO_STREAM_READ_ARRAY_TERM_EN
    return (w == TERM);
`else
    return 1'b0 && (w == TERM);
`endif
  endfunction

  // Outputs are gated by nrst so nothing handshakes during a reset cycle.
  always_comb begin
    bus.arr_valid = nrst && vld_p1;
    bus.arr_we    = bus.arr_valid;
    bus.arr_addr  = arr_addr_p1;
    bus.arr_di    = arr_di_p1;
    bus.out_valid = nrst && (state == DONE);
    bus.out_count = count;
  end

  always_comb begin
    slot_free     = !bus.arr_valid || bus.arr_ready;
    bus.in_ready  = nrst && (state == IDLE);
    bus.sIn_ready = nrst && (state == RUN) && (remaining != '0) && slot_free;
    cmd_fire      = bus.in_valid && bus.in_ready;
    sin_fire      = bus.sIn_valid && bus.sIn_ready;
    is_term       = is_terminator(bus.sIn);
    out_fire      = bus.out_valid && bus.out_ready;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_fire) state_nxt = RUN;
      RUN:  if ((remaining == '0) && slot_free) state_nxt = DONE;
      DONE: if (out_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // p0 -> p1: accepted stream word becomes the pending array request.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      remaining   <= '0;
      ptr         <= '0;
      count       <= '0;
      vld_p1      <= 1'b0;
      arr_addr_p1 <= '0;
      arr_di_p1   <= '0;
    end else begin
      if (cmd_fire) begin
        ptr       <= bus.base;
        remaining <= bus.len;
        count     <= '0;
      end
      if (sin_fire) begin
        if (is_term) begin
          remaining <= '0;
        end else begin
          arr_addr_p1 <= ptr;
          arr_di_p1   <= bus.sIn;
          ptr         <= ptr + ADDR_N'(1);
          remaining   <= remaining - (ADDR_N+1)'(1);
          count       <= count + (ADDR_N+1)'(1);
        end
      end
      if (sin_fire && !is_term) vld_p1 <= 1'b1;
      else if (bus.arr_ready)   vld_p1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_stream_read_array_burst.sv
// Randomised scoreboard bench for io_stream_read_array_burst: a burst-level model predicts writes and counts.
module tb_io_stream_read_array_burst;
  localparam int          INT_N  = 8;
  localparam int          ADDR_N = 8;
  localparam logic [7:0]  TERM   = 8'h00;

  logic clk  = 1'b0;
  logic nrst = 1'b0;

  io_stream_read_array_burst_if #(.INT_N(INT_N), .ADDR_N(ADDR_N)) bus ();

  io_stream_read_array_burst #(.INT_N(INT_N), .ADDR_N(ADDR_N), .TERM(TERM)) u_dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc   = 0;
  wr_t        exp_wr[$];
  int         exp_cnt[$];
  wr_t        e_wr;
  int         e_cnt;
  logic [7:0] mem [256];
  logic [7:0] words[$];
  logic       sin_fire   = 1'b0;
  int         out_seen   = 0;
  int         wr_seen    = 0;
  int         first_wr   = 0;
  int         last_wr    = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] stall_addr;
  logic [7:0] stall_di;
  logic       ov_prev    = 1'b0;
  logic [8:0] ov_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples mid-cycle and compares against queued expectations.
  always @(negedge clk) begin
    sin_fire = bus.sIn_valid && bus.sIn_ready;
    if (stall_prev && bus.arr_valid) begin
      check("stall_addr_stable", int'(bus.arr_addr), int'(stall_addr));
      check("stall_data_stable", int'(bus.arr_di), int'(stall_di));
    end
    if (bus.arr_valid) check("arr_we_eq_valid", int'(bus.arr_we), 1);
    if (bus.arr_valid && bus.arr_ready) begin
      if (exp_wr.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        e_wr = exp_wr.pop_front();
        check("write_addr", int'(bus.arr_addr), int'(e_wr.addr));
        check("write_data", int'(bus.arr_di), int'(e_wr.data));
      end
      mem[bus.arr_addr] = bus.arr_di;
      if (wr_seen == 0) first_wr = cyc;
      last_wr = cyc;
      wr_seen++;
    end
    stall_prev = bus.arr_valid && !bus.arr_ready;
    stall_addr = bus.arr_addr;
    stall_di   = bus.arr_di;
    if (ov_prev && bus.out_valid) check("out_count_stable", int'(bus.out_count), int'(ov_cnt));
    ov_prev = bus.out_valid && !bus.out_ready;
    ov_cnt  = bus.out_count;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_cnt.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        e_cnt = exp_cnt.pop_front();
        check("out_count", int'(bus.out_count), e_cnt);
      end
      out_seen++;
    end
  end

  task automatic drive_burst(input logic [7:0] b, input int l, input int mode,
                             input bit full, input int abort_after);
    int  n        = 0;
    int  consumed = 0;
    int  idx      = 0;
    int  seen0;
    bit  done     = 0;
    bit  accepted = 0;
    for (int i = 0; i < l; i++) begin
      consumed++;
`ifdef IO_STREAM_READ_ARRAY_TERM_EN
      if (words[i] == TERM) break;
`endif
      exp_wr.push_back('{addr: 8'(b + i), data: words[i]});
      n++;
    end
    if (abort_after == 0) exp_cnt.push_back(n);

    bus.sIn_valid = 1'b0;
    bus.in_valid  = 1'b1;
    bus.base      = b;
    bus.len       = 9'(l);
    for (int w = 0; w < 50; w++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        accepted = 1;
        break;
      end
    end
    if (!accepted) begin
      check("cmd_accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wr_seen = 0;
    seen0   = out_seen;

    for (int k = 0; k < 4000; k++) begin
      bus.sIn_valid = (idx < words.size()) && (full || ($urandom % 4 != 0));
      bus.sIn       = (idx < words.size()) ? words[idx] : 8'h00;
      if (mode == 0)      bus.arr_ready = 1'b1;
      else if (mode == 1) bus.arr_ready = (k % 2 == 0);
      else                bus.arr_ready = 1'($urandom % 2);
      bus.out_ready = full ? 1'b1 : 1'($urandom % 2);
      if (abort_after != 0 && k == abort_after) nrst = 1'b0;
      @(posedge clk); #1;
      if (sin_fire) idx++;
      if (!nrst) begin
        nrst = 1'b1;
        bus.sIn_valid = 1'b0;
        exp_wr.delete();
        exp_cnt.delete();
        @(negedge clk);
        check("abort_in_ready", int'(bus.in_ready), 1);
        check("abort_arr_valid", int'(bus.arr_valid), 0);
        check("abort_out_valid", int'(bus.out_valid), 0);
        check("abort_sin_ready", int'(bus.sIn_ready), 0);
        @(posedge clk); #1;
        return;
      end
      if (out_seen != seen0) begin
        done = 1;
        break;
      end
    end
    bus.sIn_valid = 1'b0;
    if (!done) check("burst_timeout", 0, 1);
    check("words_consumed", idx, consumed);
    check("writes_outstanding", exp_wr.size(), 0);
    if (full && mode == 0 && n > 0) check("one_write_per_cycle", last_wr - first_wr, n - 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.base      = '0;
    bus.len       = '0;
    bus.sIn       = 8'hAA;
    bus.sIn_valid = 1'b1;
    bus.arr_ready = 1'b1;
    bus.out_ready = 1'b1;
    nrst          = 1'b0;

    // Reset held three cycles with the stream offering data.
    repeat (3) begin
      @(negedge clk);
      check("rst_in_ready",  int'(bus.in_ready),  0);
      check("rst_sin_ready", int'(bus.sIn_ready), 0);
      check("rst_arr_valid", int'(bus.arr_valid), 0);
      check("rst_arr_we",    int'(bus.arr_we),    0);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_arr_addr",  int'(bus.arr_addr),  0);
      check("rst_arr_di",    int'(bus.arr_di),    0);
      check("rst_out_count", int'(bus.out_count), 0);
    end
    check("rst_no_write", wr_seen, 0);
    @(posedge clk); #1;
    nrst = 1'b1;
    bus.sIn_valid = 1'b0;
    @(posedge clk); #1;

    // base 0, len 16, ascending data, array always ready.
    words.delete();
    for (int i = 0; i < 16; i++) words.push_back(8'(i + 1) == 8'h01 && TERM == 8'h00 ? 8'(i) : 8'(i));
    words[0] = 8'h10;
    drive_burst(8'd0, 16, 0, 1'b1, 0);
    check("mem_addr5", int'(mem[5]), 5);

    // Address wrap from 250.
    words.delete();
    for (int i = 0; i < 10; i++) words.push_back(8'(8'h80 + i));
    drive_burst(8'd250, 10, 2, 1'b0, 0);
    check("wrap_mem255", int'(mem[255]), 8'h85);
    check("wrap_mem0",   int'(mem[0]),   8'h86);

    // Array ready toggling each cycle.
    words.delete();
    for (int i = 0; i < 12; i++) words.push_back(8'(8'h40 + 3 * i));
    drive_burst(8'd7, 12, 1, 1'b1, 0);

    // len == 0: result two cycles after accept, stream never ready.
    exp_cnt.push_back(0);
    bus.out_ready = 1'b1;
    bus.sIn_valid = 1'b1;
    bus.sIn       = 8'h55;
    bus.in_valid  = 1'b1;
    bus.base      = 8'd3;
    bus.len       = 9'd0;
    @(negedge clk);
    check("len0_in_ready", int'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("len0_out_valid_c1", int'(bus.out_valid), 0);
    check("len0_sin_ready_c1", int'(bus.sIn_ready), 0);
    @(negedge clk);
    check("len0_out_valid_c2", int'(bus.out_valid), 1);
    check("len0_sin_ready_c2", int'(bus.sIn_ready), 0);
    @(posedge clk); #1;
    bus.sIn_valid = 1'b0;

    // Reset in the middle of a burst, then a normal burst to confirm recovery.
    words.delete();
    for (int i = 0; i < 20; i++) words.push_back(8'($urandom_range(1, 255)));
    drive_burst(8'd100, 20, 2, 1'b0, 8);
    words.delete();
    for (int i = 0; i < 6; i++) words.push_back(8'($urandom_range(1, 255)));
    drive_burst(8'd60, 6, 0, 1'b0, 0);

    // Terminator sequence 5,6,0,9.
    words.delete();
    words.push_back(8'd5); words.push_back(8'd6); words.push_back(8'd0); words.push_back(8'd9);
`ifdef IO_STREAM_READ_ARRAY_TERM_EN
    drive_burst(8'd40, 8, 0, 1'b1, 0);
`else
    drive_burst(8'd40, 4, 0, 1'b1, 0);
`endif

    // Randomised bursts, the first one covering the full address space.
    for (int t = 0; t < 20; t++) begin
      int l;
      l = (t == 0) ? 256 : $urandom_range(0, 40);
      words.delete();
      for (int i = 0; i < l + int'($urandom % 3); i++) words.push_back(8'($urandom));
      drive_burst(8'($urandom), l, int'($urandom % 3), 1'b0, 0);
    end

    repeat (3) @(posedge clk);
    check("final_exp_writes_empty", exp_wr.size(), 0);
    check("final_exp_counts_empty", exp_cnt.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
